// File: rtl/cpu_pipeline_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pipeline_pkg
// Types and helpers shared by the EX->MEM sequencer slice.
//   ex_mem_bundle_t : every field held between instruction accept and capture
//   seq_state_t     : sequencer FSM states
//   FSC_WORD_BIT    : fsc bit that selects a word access
//   fsc_is_byte()   : byte-access decode of the fsc field
// ---------------------------------------------------------------------------
package cpu_pipeline_pkg;

  localparam int FSC_WORD_BIT = 1;

  typedef struct packed {
    logic        mem_load_store;
    logic        inverse_op;
    logic [2:0]  fsc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [23:0] imm;
    logic [31:0] rd_data;
    logic [4:0]  rd_sel;
  } ex_mem_bundle_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_WAIT   = 2'd2,
    ST_COMMIT = 2'd3
  } seq_state_t;

  // Byte access is encoded by fsc[0] low; only meaningful when the word bit
  // is clear.
  function automatic logic fsc_is_byte(input logic [2:0] fsc);
    return ~fsc[0];
  endfunction

endpackage

// File: rtl/cpu_stall_counter.sv
// ---------------------------------------------------------------------------
// cpu_stall_counter
// Saturating up-counter with enable; sticks at all-ones.
//   clk, rst : clock, async active-high reset (count clears to 0)
//   en       : count this cycle
//   count    : current value
// ---------------------------------------------------------------------------
module cpu_stall_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (en && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/cpu_mem_stage_sequencer.sv
// ---------------------------------------------------------------------------
// cpu_mem_stage_sequencer
// Pipeline register + handshake controller between EX and MEM. Accepts one
// instruction from EX, holds it, issues a one-cycle pl_instruction_valid to
// MEM, waits for pl_stage_complete, then offers the result to write-back
// with a valid/ready handshake. Counts MEM stall cycles.
//
// Ports:
//   clk, rst                : clock, async active-high reset
//   flush                   : kill in-flight instruction (no WB commit)
//   ex_valid / ex_ready     : EX handshake; ex_* instruction fields
//   mem_load_store .. register_select_in : held fields driven to MEM
//   pl_instruction_valid    : one-cycle issue pulse to MEM
//   pl_stage_complete, rd_data_out, register_select_out : MEM result
//   wb_valid / wb_ready     : WB handshake; wb_rd_data, wb_rd_sel, wb_write_en
//   wb_trap, wb_trap_addr   : misaligned-access trap report
//   stall_cycles            : saturating count of WAIT cycles
//
// Build option: define MEM_MISALIGN_TRAP_EN to enable the misaligned
// load/store check; without it wb_trap and wb_trap_addr are tied to 0.
//
// state  | meaning
// IDLE   | empty, ready for an instruction from EX
// ISSUE  | pl_instruction_valid high; MEM may complete in this cycle
// WAIT   | MEM busy; counting stall cycles
// COMMIT | result held for WB until wb_ready
// ---------------------------------------------------------------------------
module cpu_mem_stage_sequencer
  import cpu_pipeline_pkg::*;
#(
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,

  input  logic                   ex_valid,
  output logic                   ex_ready,
  input  logic                   ex_mem_load_store,
  input  logic                   ex_inverse_op,
  input  logic [2:0]             ex_fsc,
  input  logic [31:0]            ex_rs1,
  input  logic [31:0]            ex_rs2,
  input  logic [23:0]            ex_imm,
  input  logic [31:0]            ex_rd_data,
  input  logic [4:0]             ex_rd_sel,

  output logic                   mem_load_store,
  output logic                   inverse_op,
  output logic [2:0]             finite_state_control,
  output logic [31:0]            rs1,
  output logic [31:0]            rs2,
  output logic [23:0]            imm,
  output logic [31:0]            rd_data_in,
  output logic [4:0]             register_select_in,
  output logic                   pl_instruction_valid,
  input  logic                   pl_stage_complete,
  input  logic [31:0]            rd_data_out,
  input  logic [4:0]             register_select_out,

  output logic                   wb_valid,
  input  logic                   wb_ready,
  output logic [31:0]            wb_rd_data,
  output logic [4:0]             wb_rd_sel,
  output logic                   wb_write_en,
  output logic                   wb_trap,
  output logic [31:0]            wb_trap_addr,

  output logic [STALL_CNT_W-1:0] stall_cycles
);

  seq_state_t     state, state_n;
  ex_mem_bundle_t hold, hold_n;
  logic           killed, killed_n;
  logic           ld_hold;
  logic           cap;
  logic           trap_n;
  logic           we_n;

  logic [31:0]    wb_rd_data_q;
  logic [4:0]     wb_rd_sel_q;
  logic           wb_write_en_q;

  // ---------------------------------------------------------------------
  // Instruction bundle formed at accept
  // ---------------------------------------------------------------------
`ifdef MEM_MISALIGN_TRAP_EN
  logic [31:0] acc_addr;
  logic        acc_word, acc_byte, acc_half, acc_misaligned;
  logic        hold_trap;
  logic [31:0] hold_addr;
  logic        wb_trap_q;
  logic [31:0] wb_trap_addr_q;

  always_comb begin
    acc_addr       = ex_rs1 + {8'b0, ex_imm};
    acc_word       = ex_fsc[FSC_WORD_BIT];
    acc_byte       = !acc_word && fsc_is_byte(ex_fsc);
    acc_half       = !acc_word && !acc_byte;
    acc_misaligned = ex_mem_load_store &&
                     ((acc_word && (acc_addr[1:0] != 2'b00)) ||
                      (acc_half && acc_addr[0]));
  end
`endif

  always_comb begin
    hold_n.mem_load_store = ex_mem_load_store;
    hold_n.inverse_op     = ex_inverse_op;
    hold_n.fsc            = ex_fsc;
    hold_n.rs1            = ex_rs1;
    hold_n.rs2            = ex_rs2;
    hold_n.imm            = ex_imm;
    hold_n.rd_data        = ex_rd_data;
    hold_n.rd_sel         = ex_rd_sel;
`ifdef MEM_MISALIGN_TRAP_EN
    // A trapping access must not reach the cache; MEM treats it as a
    // pass-through op and completes in ISSUE.
    if (acc_misaligned) hold_n.mem_load_store = 1'b0;
`endif
  end

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      killed <= 1'b0;
    end else begin
      state  <= state_n;
      killed <= killed_n;
    end
  end

  always_comb begin
    ex_ready = !flush &&
               ((state == ST_IDLE) || ((state == ST_COMMIT) && wb_ready));
  end

  always_comb begin
    state_n  = state;
    killed_n = killed;
    ld_hold  = 1'b0;
    cap      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (ex_valid && ex_ready) begin
          ld_hold = 1'b1;
          state_n = ST_ISSUE;
        end
      end
      ST_ISSUE, ST_WAIT: begin
        // The cache access cannot be aborted, so a flush only marks the
        // instruction dead; completion is still awaited.
        if (flush) killed_n = 1'b1;
        if (pl_stage_complete) begin
          if (killed || flush) begin
            state_n = ST_IDLE;
          end else begin
            cap     = 1'b1;
            state_n = ST_COMMIT;
          end
        end else begin
          state_n = ST_WAIT;
        end
      end
      ST_COMMIT: begin
        if (flush) begin
          state_n = ST_IDLE;
        end else if (wb_ready) begin
          if (ex_valid) begin
            ld_hold = 1'b1;
            state_n = ST_ISSUE;
          end else begin
            state_n = ST_IDLE;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
    if (ld_hold) killed_n = 1'b0;
  end

  assign pl_instruction_valid = (state == ST_ISSUE);
  // Gated by flush so WB never sees a valid in the cycle it is killed.
  assign wb_valid             = (state == ST_COMMIT) && !flush;

  // ---------------------------------------------------------------------
  // Hold registers and result capture
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold <= '0;
    end else if (ld_hold) begin
      hold <= hold_n;
    end
  end

`ifdef MEM_MISALIGN_TRAP_EN
  assign trap_n = hold_trap;
`else
  assign trap_n = 1'b0;
`endif

  // Write enable is resolved at capture, since a back-to-back accept
  // overwrites the hold registers while the result is still in WB.
  assign we_n = (register_select_out != 5'd0) &&
                !(hold.mem_load_store && hold.inverse_op) && !trap_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_rd_data_q  <= '0;
      wb_rd_sel_q   <= '0;
      wb_write_en_q <= 1'b0;
    end else if (cap) begin
      wb_rd_data_q  <= rd_data_out;
      wb_rd_sel_q   <= register_select_out;
      wb_write_en_q <= we_n;
    end
  end

`ifdef MEM_MISALIGN_TRAP_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_trap      <= 1'b0;
      hold_addr      <= '0;
      wb_trap_q      <= 1'b0;
      wb_trap_addr_q <= '0;
    end else begin
      if (ld_hold) begin
        hold_trap <= acc_misaligned;
        hold_addr <= acc_addr;
      end
      if (cap) begin
        wb_trap_q      <= hold_trap;
        wb_trap_addr_q <= hold_trap ? hold_addr : 32'd0;
      end
    end
  end

  assign wb_trap      = wb_trap_q;
  assign wb_trap_addr = wb_trap_addr_q;
`else
  assign wb_trap      = 1'b0;
  assign wb_trap_addr = 32'd0;
`endif

  assign wb_rd_data  = wb_rd_data_q;
  assign wb_rd_sel   = wb_rd_sel_q;
  assign wb_write_en = wb_write_en_q;

  assign mem_load_store       = hold.mem_load_store;
  assign inverse_op           = hold.inverse_op;
  assign finite_state_control = hold.fsc;
  assign rs1                  = hold.rs1;
  assign rs2                  = hold.rs2;
  assign imm                  = hold.imm;
  assign rd_data_in           = hold.rd_data;
  assign register_select_in   = hold.rd_sel;

  // ---------------------------------------------------------------------
  // Stall monitor
  // ---------------------------------------------------------------------
  cpu_stall_counter #(
    .W (STALL_CNT_W)
  ) u_stall_counter (
    .clk   (clk),
    .rst   (rst),
    .en    (state == ST_WAIT),
    .count (stall_cycles)
  );

endmodule

// File: tb/tb_cpu_mem_stage_sequencer.sv
// ---------------------------------------------------------------------------
// tb_cpu_mem_stage_sequencer
// Directed vectors for the EX->MEM sequencer. A minimal MEM model completes
// non-memory ops immediately (passing rd_data through) and completes
// load/store ops when mem_done is driven high.
// ---------------------------------------------------------------------------
module tb_cpu_mem_stage_sequencer;

  localparam int SW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          ex_valid;
  logic          ex_ready;
  logic          ex_mem_load_store;
  logic          ex_inverse_op;
  logic [2:0]    ex_fsc;
  logic [31:0]   ex_rs1;
  logic [31:0]   ex_rs2;
  logic [23:0]   ex_imm;
  logic [31:0]   ex_rd_data;
  logic [4:0]    ex_rd_sel;
  logic          mem_load_store;
  logic          inverse_op;
  logic [2:0]    finite_state_control;
  logic [31:0]   rs1;
  logic [31:0]   rs2;
  logic [23:0]   imm;
  logic [31:0]   rd_data_in;
  logic [4:0]    register_select_in;
  logic          pl_instruction_valid;
  logic          pl_stage_complete;
  logic [31:0]   rd_data_out;
  logic [4:0]    register_select_out;
  logic          wb_valid;
  logic          wb_ready;
  logic [31:0]   wb_rd_data;
  logic [4:0]    wb_rd_sel;
  logic          wb_write_en;
  logic          wb_trap;
  logic [31:0]   wb_trap_addr;
  logic [SW-1:0] stall_cycles;

  logic          mem_done;
  logic [31:0]   mem_data;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign pl_stage_complete   = mem_load_store ? mem_done : 1'b1;
  assign rd_data_out         = mem_load_store ? mem_data : rd_data_in;
  assign register_select_out = register_select_in;

  cpu_mem_stage_sequencer #(.STALL_CNT_W(SW)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .flush                (flush),
    .ex_valid             (ex_valid),
    .ex_ready             (ex_ready),
    .ex_mem_load_store    (ex_mem_load_store),
    .ex_inverse_op        (ex_inverse_op),
    .ex_fsc               (ex_fsc),
    .ex_rs1               (ex_rs1),
    .ex_rs2               (ex_rs2),
    .ex_imm               (ex_imm),
    .ex_rd_data           (ex_rd_data),
    .ex_rd_sel            (ex_rd_sel),
    .mem_load_store       (mem_load_store),
    .inverse_op           (inverse_op),
    .finite_state_control (finite_state_control),
    .rs1                  (rs1),
    .rs2                  (rs2),
    .imm                  (imm),
    .rd_data_in           (rd_data_in),
    .register_select_in   (register_select_in),
    .pl_instruction_valid (pl_instruction_valid),
    .pl_stage_complete    (pl_stage_complete),
    .rd_data_out          (rd_data_out),
    .register_select_out  (register_select_out),
    .wb_valid             (wb_valid),
    .wb_ready             (wb_ready),
    .wb_rd_data           (wb_rd_data),
    .wb_rd_sel            (wb_rd_sel),
    .wb_write_en          (wb_write_en),
    .wb_trap              (wb_trap),
    .wb_trap_addr         (wb_trap_addr),
    .stall_cycles         (stall_cycles)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic ls, input logic inv, input logic [2:0] fsc,
                           input logic [31:0] a, input logic [31:0] d2,
                           input logic [23:0] im, input logic [31:0] rdd,
                           input logic [4:0] rsel);
    ex_mem_load_store = ls;
    ex_inverse_op     = inv;
    ex_fsc            = fsc;
    ex_rs1            = a;
    ex_rs2            = d2;
    ex_imm            = im;
    ex_rd_data        = rdd;
    ex_rd_sel         = rsel;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; ex_valid = 1'b0; wb_ready = 1'b0;
    mem_done = 1'b0; mem_data = 32'd0;
    set_instr(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 24'd0, 32'd0, 5'd0);
    tick(); tick();

    // reset state
    chk("rst_pl_valid", {31'd0, pl_instruction_valid}, 32'd0);
    chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst_wb_data", wb_rd_data, 32'd0);
    chk("rst_wb_we", {31'd0, wb_write_en}, 32'd0);
    chk("rst_hold_rs1", rs1, 32'd0);
    chk("rst_stall", {16'd0, stall_cycles}, 32'd0);
    chk("rst_ex_ready", {31'd0, ex_ready}, 32'd1);
    rst = 1'b0;
    tick();

    // non-memory op
    set_instr(1'b0, 1'b0, 3'd0, 32'h10, 32'd0, 24'd0, 32'h1234, 5'd5);
    ex_valid = 1'b1; #1;
    chk("t1_ex_ready_idle", {31'd0, ex_ready}, 32'd1);
    tick();
    ex_valid = 1'b0; #1;
    chk("t1_issue_pulse", {31'd0, pl_instruction_valid}, 32'd1);
    chk("t1_issue_ex_ready", {31'd0, ex_ready}, 32'd0);
    chk("t1_rd_data_in", rd_data_in, 32'h1234);
    tick();
    chk("t1_commit_valid", {31'd0, wb_valid}, 32'd1);
    chk("t1_pulse_gone", {31'd0, pl_instruction_valid}, 32'd0);
    chk("t1_wb_data", wb_rd_data, 32'h1234);
    chk("t1_wb_sel", {27'd0, wb_rd_sel}, 32'd5);
    chk("t1_wb_we", {31'd0, wb_write_en}, 32'd1);
    chk("t1_stall", {16'd0, stall_cycles}, 32'd0);
    wb_ready = 1'b1; #1;
    chk("t1_ex_ready_commit", {31'd0, ex_ready}, 32'd1);
    tick();
    wb_ready = 1'b0; #1;
    chk("t1_idle_wb_valid", {31'd0, wb_valid}, 32'd0);

    // load completing 3 cycles after ISSUE
    set_instr(1'b1, 1'b0, 3'b010, 32'h1000, 32'd0, 24'd0, 32'd0, 5'd3);
    ex_valid = 1'b1; mem_done = 1'b0;
    tick();
    ex_valid = 1'b0; #1;
    chk("t2_issue_pulse", {31'd0, pl_instruction_valid}, 32'd1);
    chk("t2_mem_ls", {31'd0, mem_load_store}, 32'd1);
    chk("t2_rs1", rs1, 32'h1000);
    tick();
    chk("t2_wait1_pulse", {31'd0, pl_instruction_valid}, 32'd0);
    chk("t2_wait1_stall", {16'd0, stall_cycles}, 32'd0);
    tick();
    chk("t2_wait2_pulse", {31'd0, pl_instruction_valid}, 32'd0);
    chk("t2_wait2_stall", {16'd0, stall_cycles}, 32'd1);
    tick();
    chk("t2_wait3_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("t2_wait3_stall", {16'd0, stall_cycles}, 32'd2);
    mem_done = 1'b1; mem_data = 32'hDEADBEEF;
    tick();
    chk("t2_commit_valid", {31'd0, wb_valid}, 32'd1);
    chk("t2_wb_data", wb_rd_data, 32'hDEADBEEF);
    chk("t2_wb_we", {31'd0, wb_write_en}, 32'd1);
    chk("t2_stall", {16'd0, stall_cycles}, 32'd3);
    wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0;

    // store; MEM holds complete high, so it finishes in ISSUE
    set_instr(1'b1, 1'b1, 3'b010, 32'h2000, 32'hA5A5, 24'd0, 32'h3333, 5'd7);
    mem_data = 32'hCAFE0001; mem_done = 1'b1;
    ex_valid = 1'b1;
    tick();
    ex_valid = 1'b0; #1;
    chk("t3_issue_ex_ready", {31'd0, ex_ready}, 32'd0);
    chk("t3_issue_pulse", {31'd0, pl_instruction_valid}, 32'd1);
    chk("t3_inverse_op", {31'd0, inverse_op}, 32'd1);
    chk("t3_rs2", rs2, 32'hA5A5);
    tick();
    chk("t3_commit_valid", {31'd0, wb_valid}, 32'd1);
    chk("t3_wb_we", {31'd0, wb_write_en}, 32'd0);
    chk("t3_ex_ready", {31'd0, ex_ready}, 32'd0);

    // WB back-pressure for 4 cycles while EX pulses a new instruction
    set_instr(1'b0, 1'b0, 3'd0, 32'h0, 32'd0, 24'd0, 32'h55, 5'd9);
    for (int i = 0; i < 4; i++) begin
      ex_valid = (i % 2 == 0); #1;
      chk("t4_ex_ready_low", {31'd0, ex_ready}, 32'd0);
      tick();
      chk("t4_wb_valid", {31'd0, wb_valid}, 32'd1);
      chk("t4_wb_data", wb_rd_data, 32'hCAFE0001);
      chk("t4_wb_sel", {27'd0, wb_rd_sel}, 32'd7);
      chk("t4_pulse", {31'd0, pl_instruction_valid}, 32'd0);
      chk("t4_hold_stable", rd_data_in, 32'h3333);
    end
    ex_valid = 1'b1; wb_ready = 1'b1; #1;
    chk("t4_b2b_ready", {31'd0, ex_ready}, 32'd1);
    tick();
    ex_valid = 1'b0; wb_ready = 1'b0; #1;
    chk("t4_b2b_pulse", {31'd0, pl_instruction_valid}, 32'd1);
    chk("t4_b2b_rd_in", rd_data_in, 32'h55);
    chk("t4_b2b_wb_valid", {31'd0, wb_valid}, 32'd0);
    tick();
    chk("t4_b2b_wb_data", wb_rd_data, 32'h55);
    chk("t4_b2b_wb_sel", {27'd0, wb_rd_sel}, 32'd9);
    chk("t4_b2b_we", {31'd0, wb_write_en}, 32'd1);
    wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0;

    // flush in WAIT, completion two cycles later
    set_instr(1'b1, 1'b0, 3'b010, 32'h1000, 32'd0, 24'd0, 32'd0, 5'd6);
    mem_done = 1'b0; mem_data = 32'h0BAD0BAD;
    ex_valid = 1'b1;
    tick();
    ex_valid = 1'b0;
    tick();
    flush = 1'b1; ex_valid = 1'b1; #1;
    chk("t5_flush_ex_ready", {31'd0, ex_ready}, 32'd0);
    tick();
    flush = 1'b0; ex_valid = 1'b0; #1;
    chk("t5_wait_no_valid", {31'd0, wb_valid}, 32'd0);
    tick();
    mem_done = 1'b1;
    tick();
    chk("t5_no_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("t5_idle_ready", {31'd0, ex_ready}, 32'd1);
    chk("t5_stall", {16'd0, stall_cycles}, 32'd6);
    tick();
    chk("t5_idle_ignore_cmpl", {31'd0, wb_valid}, 32'd0);
    chk("t5_idle_no_pulse", {31'd0, pl_instruction_valid}, 32'd0);
    set_instr(1'b0, 1'b0, 3'd0, 32'h0, 32'd0, 24'd0, 32'h77, 5'd4);
    ex_valid = 1'b1;
    tick();
    ex_valid = 1'b0; #1;
    chk("t5_next_pulse", {31'd0, pl_instruction_valid}, 32'd1);
    tick();
    chk("t5_next_valid", {31'd0, wb_valid}, 32'd1);
    chk("t5_next_data", wb_rd_data, 32'h77);

    // flush in COMMIT drops the result
    flush = 1'b1; #1;
    chk("t5_commit_flush_valid", {31'd0, wb_valid}, 32'd0);
    chk("t5_commit_flush_ready", {31'd0, ex_ready}, 32'd0);
    tick();
    flush = 1'b0; #1;
    chk("t5_after_flush_valid", {31'd0, wb_valid}, 32'd0);
    chk("t5_after_flush_ready", {31'd0, ex_ready}, 32'd1);

    // rd_sel = 0 never writes
    set_instr(1'b0, 1'b0, 3'd0, 32'h0, 32'd0, 24'd0, 32'h99, 5'd0);
    ex_valid = 1'b1;
    tick();
    ex_valid = 1'b0;
    tick();
    chk("t6_x0_valid", {31'd0, wb_valid}, 32'd1);
    chk("t6_x0_we", {31'd0, wb_write_en}, 32'd0);
    wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0;

    // misaligned word load
    set_instr(1'b1, 1'b0, 3'b010, 32'h1002, 32'd0, 24'd0, 32'd0, 5'd2);
    mem_done = 1'b1; mem_data = 32'h12345678;
    ex_valid = 1'b1;
    tick();
    ex_valid = 1'b0; #1;
`ifdef MEM_MISALIGN_TRAP_EN
    chk("t7_ls_forced", {31'd0, mem_load_store}, 32'd0);
    tick();
    chk("t7_valid", {31'd0, wb_valid}, 32'd1);
    chk("t7_trap", {31'd0, wb_trap}, 32'd1);
    chk("t7_trap_addr", wb_trap_addr, 32'h00001002);
    chk("t7_we", {31'd0, wb_write_en}, 32'd0);
`else
    chk("t7_ls_kept", {31'd0, mem_load_store}, 32'd1);
    tick();
    chk("t7_valid", {31'd0, wb_valid}, 32'd1);
    chk("t7_trap", {31'd0, wb_trap}, 32'd0);
    chk("t7_trap_addr", wb_trap_addr, 32'd0);
    chk("t7_data", wb_rd_data, 32'h12345678);
    chk("t7_we", {31'd0, wb_write_en}, 32'd1);
`endif
    wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0; #1;
    chk("t7_idle", {31'd0, wb_valid}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cpu_mem_stage_sequencer.md
Name: cpu_mem_stage_sequencer

Overview:
- Pipeline register and handshake controller placed directly upstream of the MEM stage (between EX and MEM).
- Accepts one instruction from EX, holds it, and issues the exactly-one-cycle pl_instruction_valid pulse the MEM stage requires.
- Waits for pl_stage_complete, captures the MEM result, and presents it to write-back with a valid/ready handshake.
- Counts memory stall cycles for performance monitoring.

Parameters:
STALL_CNT_W, 16, width of saturating stall-cycle counter

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
flush  in  1  kill in-flight instruction (no WB commit)
ex_valid  in  1  EX presents instruction
ex_ready  out  1  sequencer accepts this cycle
ex_mem_load_store  in  1  instruction is load/store
ex_inverse_op  in  1  1 = store
ex_fsc  in  3  finite state control (access size / sign-extend)
ex_rs1  in  32  base address
ex_rs2  in  32  store data
ex_imm  in  24  offset (zero-extended)
ex_rd_data  in  32  ALU result for non-memory ops
ex_rd_sel  in  5  destination register
mem_load_store, inverse_op, finite_state_control, rs1, rs2, imm, rd_data_in, register_select_in  out  1/1/3/32/32/24/32/5  held fields to MEM stage
pl_instruction_valid  out  1  one-cycle issue pulse to MEM
pl_stage_complete  in  1  MEM result valid
rd_data_out  in  32  MEM result
register_select_out  in  5  MEM destination passthrough
wb_valid  out  1  result available to WB
wb_ready  in  1  WB consumes
wb_rd_data  out  32  captured result
wb_rd_sel  out  5  captured destination
wb_write_en  out  1  rd_sel != 0 and not a store
wb_trap  out  1  misaligned-access trap (see Optional Feature)
wb_trap_addr  out  32  faulting address
stall_cycles  out  STALL_CNT_W  saturating count of WAIT cycles

Behaviour:
- States: IDLE, ISSUE, WAIT, COMMIT.
- Reset values:
  - state = IDLE.
  - All held fields and all wb_* outputs = 0; pl_instruction_valid = 0; stall_cycles = 0.
- ex_ready = (state == IDLE) || (state == COMMIT && wb_ready).
- IDLE:
  - On ex_valid && ex_ready: latch all ex_* fields into hold registers; next state ISSUE.
- ISSUE:
  - pl_instruction_valid = 1 for this cycle only.
  - Hold registers stay constant from ISSUE until the result is captured.
  - If pl_stage_complete: capture rd_data_out / register_select_out into the wb registers; next state COMMIT.
  - Otherwise: next state WAIT.
  - A non-memory op completes combinationally in ISSUE, giving 1-cycle latency ISSUE→COMMIT.
- WAIT:
  - pl_instruction_valid = 0.
  - stall_cycles increments each cycle and saturates at all-ones.
  - On pl_stage_complete: capture result; next state COMMIT.
- Completion sampling:
  - pl_stage_complete is sampled only in ISSUE and WAIT.
  - It is ignored in IDLE and COMMIT, because the MEM stage holds it high between instructions.
- COMMIT:
  - wb_valid = 1; wb outputs stable while wb_valid && !wb_ready.
  - On wb_ready with no new ex_valid: next state IDLE.
  - On wb_ready with ex_valid: latch the new instruction; next state ISSUE (back-to-back, one instruction per 2 cycles minimum).
- wb_write_en = (captured rd_sel != 0) && !(held mem_load_store && held inverse_op).
- flush:
  - In IDLE: no effect.
  - In COMMIT: drop wb_valid; go to IDLE.
  - In ISSUE or WAIT: set a killed flag. The sequencer still waits for pl_stage_complete, because the cache access cannot be aborted. It then returns to IDLE without raising wb_valid.
  - flush and ex_valid in the same cycle: flush wins; ex_ready = 0.
- rst mid-operation returns to IDLE immediately. MEM/cache recovery is owned by that block's own rst.

Optional Feature:
- Macro: MEM_MISALIGN_TRAP_EN.
- With the macro defined:
  - At accept, compute addr = ex_rs1 + {8'b0, ex_imm}.
  - Access size: word = ex_fsc[1]; byte = ~ex_fsc[0]; half otherwise.
  - Misaligned = (word && addr[1:0] != 0) || (half && addr[0]).
  - For a misaligned access: the held mem_load_store is forced to 0, so MEM passes through and completes in ISSUE. In COMMIT, wb_trap = 1, wb_trap_addr = addr, wb_write_en = 0.
- Without the macro: no check; wb_trap tied 0, wb_trap_addr tied 0.

Decomposition:
- Shared package cpu_pipeline_pkg contains:
  - ex_mem_bundle_t: packed struct of all held fields.
  - seq_state_t: enum of the four states.
  - Constant FSC_WORD_BIT = 1.
  - Function fsc_is_byte().
- One sub-module, cpu_stall_counter: saturating counter with enable.

Test Plan:
- Non-memory op, rd_sel = 5, rd_data = 0x1234 → pl_instruction_valid pulses 1 cycle; wb_valid 2 cycles after accept; wb_rd_data = 0x1234; wb_write_en = 1; stall_cycles = 0.
- Load with pl_stage_complete delayed 3 cycles after ISSUE, rd_data_out = 0xDEADBEEF → pl_instruction_valid high exactly 1 cycle; wb_rd_data = 0xDEADBEEF; stall_cycles = 3.
- Store (inverse_op = 1, rd_sel = 7) → wb_write_en = 0; ex_ready low until COMMIT && wb_ready.
- wb_ready held low 4 cycles in COMMIT → wb outputs stable; ex_ready = 0; pulsing ex_valid is not accepted.
- flush asserted in WAIT, completion 2 cycles later → no wb_valid; state IDLE; next instruction accepted normally.
- With MEM_MISALIGN_TRAP_EN: LW, rs1 = 0x1002, imm = 0 → mem_load_store = 0 to MEM; wb_trap = 1; wb_trap_addr = 0x00001002; wb_write_en = 0.
